// File: rtl/wb_burst_responder.sv
// Wishbone B3 responder: classic and incrementing-burst access to an internal word memory,
// programmable first-beat wait states, out-of-range error termination and beat counters.
module wb_burst_responder #(
   parameter int unsigned AW = 8,
   parameter int unsigned dw = 32
) (
   input  logic              wb_clk_i,
   input  logic              wb_resetn,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [29:0]       wb_addr_i,
   input  logic [dw-1:0]     wb_dat_i,
   input  logic [dw/8-1:0]   wb_sel_i,
   input  logic [2:0]        wb_cti_i,
   output logic [dw-1:0]     wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   input  logic [3:0]        cfg_wait,
   output logic [15:0]       wr_cnt_o,
   output logic [15:0]       rd_cnt_o
);

   localparam int unsigned DEPTH    = 2 ** AW;
   localparam int unsigned SW       = dw / 8;
   localparam logic [2:0]  CTI_INCR = 3'b010;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wait_q, wait_d;
   logic [29:0]     addr_q, addr_d;
   logic            ack_d, err_d;
   logic [dw-1:0]   dat_d;
   logic [15:0]     wr_cnt_d, rd_cnt_d;
   logic [29:0]     term_addr_c;
   logic            term_c;
   logic            req_c;
   logic            beat_done_c;
   logic            mem_we_c;

   logic [dw-1:0]   mem [DEPTH];

   function automatic logic in_range(input logic [29:0] a);
      return (a >> AW) == 30'd0;
   endfunction

   assign req_c       = wb_cyc_i & wb_stb_i;
   // A beat transfers on the edge where the master still strobes during our ack
   assign beat_done_c = req_c & wb_ack_o;
   assign mem_we_c    = beat_done_c & wb_we_i;

   // Next state, next termination and counters
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      addr_d      = addr_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      dat_d       = '0;
      wr_cnt_d    = wr_cnt_o;
      rd_cnt_d    = rd_cnt_o;
      term_c      = 1'b0;
      term_addr_c = addr_q;

      if (beat_done_c) begin
         if (wb_we_i) wr_cnt_d = wr_cnt_o + 16'd1;
         else         rd_cnt_d = rd_cnt_o + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               addr_d      = wb_addr_i;
               term_addr_c = wb_addr_i;
               if (cfg_wait == 4'd0) begin
                  term_c  = 1'b1;
                  state_d = S_ACK;
               end else begin
                  wait_d  = cfg_wait;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!wb_cyc_i) begin
               wait_d  = 4'd0;
               state_d = S_IDLE;
            end else if (wb_stb_i) begin
               wait_d = wait_q - 4'd1;
               if (wait_q == 4'd1) begin
                  term_c  = 1'b1;
                  state_d = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (beat_done_c && (wb_cti_i == CTI_INCR)) begin
               addr_d      = addr_q + 30'd1;
               term_addr_c = addr_q + 30'd1;
               term_c      = 1'b1;
               state_d     = S_BURST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BURST: begin
            if (!wb_cyc_i || wb_err_o) begin
               state_d = S_IDLE;
            end else if (!wb_stb_i) begin
               state_d = S_BURST;
            end else if (!wb_ack_o) begin
               // resume after a master stall: re-terminate the pending beat
               term_c = 1'b1;
            end else if (wb_cti_i == CTI_INCR) begin
               addr_d      = addr_q + 30'd1;
               term_addr_c = addr_q + 30'd1;
               term_c      = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (term_c) begin
         if (in_range(term_addr_c)) begin
            ack_d = 1'b1;
            if (!wb_we_i) dat_d = mem[term_addr_c[AW-1:0]];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
      if (!wb_resetn) begin
         state_q  <= S_IDLE;
         wait_q   <= 4'd0;
         addr_q   <= 30'd0;
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         wr_cnt_o <= 16'd0;
         rd_cnt_o <= 16'd0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         addr_q   <= addr_d;
         wb_ack_o <= ack_d;
         wb_err_o <= err_d;
         wb_dat_o <= dat_d;
         wr_cnt_o <= wr_cnt_d;
         rd_cnt_o <= rd_cnt_d;
      end
   end

   // Byte-enabled memory write; contents survive reset
   always_ff @(posedge wb_clk_i) begin
      if (mem_we_c) begin
         for (int unsigned b = 0; b < SW; b++) begin
            if (wb_sel_i[b]) mem[addr_q[AW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_burst_responder.sv
// Self-checking bench for wb_burst_responder: vector table, directed corner sequences and
// randomized classic/burst traffic against a word-array reference model.
module tb_wb_burst_responder;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [29:0] addr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [3:0]  cfg_wait;
   logic [31:0] dat_r;
   logic        ack, err;
   logic [15:0] wr_cnt, rd_cnt;

   wb_burst_responder #(.AW(AW), .dw(32)) dut (
      .wb_clk_i (clk),
      .wb_resetn(rst_n),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_addr_i(addr),
      .wb_dat_i (dat_w),
      .wb_sel_i (sel),
      .wb_cti_i (cti),
      .wb_dat_o (dat_r),
      .wb_ack_o (ack),
      .wb_err_o (err),
      .cfg_wait (cfg_wait),
      .wr_cnt_o (wr_cnt),
      .rd_cnt_o (rd_cnt)
   );

   always #5 clk = ~clk;

   int cyc_no = 0;
   always @(posedge clk) cyc_no <= cyc_no + 1;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [15:0] exp_wr, exp_rd;

   logic [31:0] bdat    [DEPTH];
   logic [3:0]  bsel    [DEPTH];
   logic [31:0] rdat    [DEPTH];
   logic        obs_ack [DEPTH];
   logic        obs_err [DEPTH];
   int          obs_lat, obs_beats;
   int          mid_wait = -1;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
      logic [3:0]  w;
      logic        exp_ack;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   function automatic bit ref_in_range(input logic [29:0] a);
      return {2'b00, a} < DEPTH;
   endfunction

   task automatic ref_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[a[AW-1:0]][8*b +: 8] = d[8*b +: 8];
   endtask

   // One classic access (n=1, classic=1) or an incrementing burst of n beats.
   // Called at a sample point just after a rising edge; returns at one too.
   task automatic xfer(input logic wr, input logic [29:0] a0, input int n,
                       input logic [3:0] w, input logic classic);
      int          cc;
      logic [29:0] a;
      logic        e_err;
      cfg_wait = w;
      cyc = 1'b1; stb = 1'b1; we = wr; addr = a0; dat_w = bdat[0]; sel = bsel[0];
      cti = classic ? 3'b000 : ((n == 1) ? 3'b111 : 3'b010);
      cc = 0;
      do begin
         @(posedge clk); #1;
         cc++;
         if (cc == 1 && mid_wait >= 0) cfg_wait = 4'(mid_wait);
      end while (!(ack || err) && cc < 40);
      obs_lat   = cc;
      obs_beats = 0;
      chk("first_latency", 32'(cc), 32'(1 + int'(w)));
      for (int i = 0; i < n; i++) begin
         a     = a0 + 30'(i);
         e_err = !ref_in_range(a);
         obs_ack[i] = ack; obs_err[i] = err; rdat[i] = dat_r;
         chk("beat_ack", 32'(ack), 32'(!e_err));
         chk("beat_err", 32'(err), 32'(e_err));
         if (!e_err) begin
            if (wr) begin
               ref_write(a, bdat[i], bsel[i]);
               exp_wr = exp_wr + 16'd1;
            end else begin
               chk("read_data", dat_r, ref_mem[a[AW-1:0]]);
               exp_rd = exp_rd + 16'd1;
            end
         end
         obs_beats++;
         @(posedge clk); #1;
         if (e_err || i == n - 1) break;
         addr  = a + 30'd1;
         dat_w = bdat[i+1];
         sel   = bsel[i+1];
         cti   = (i + 1 == n - 1) ? 3'b111 : 3'b010;
      end
      cyc = 1'b0; stb = 1'b0; cti = 3'b000;
      chk("term_after_end", 32'(ack | err), 32'd0);
      chk("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
      chk("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
   endtask

   initial begin
      int          t0;
      int          n;
      logic        rwe, cls, saw;
      logic [29:0] ra;
      logic [3:0]  rw;
      logic [31:0] bvals [5];

      vt[0]  = '{1'b1, 30'h10,       32'h11223344, 4'hF, 4'd0, 1'b1, 1'b0, 32'h0,        1};
      vt[1]  = '{1'b0, 30'h10,       32'h0,        4'hF, 4'd0, 1'b1, 1'b0, 32'h11223344, 1};
      vt[2]  = '{1'b1, 30'h30,       32'hFFFFFFFF, 4'hF, 4'd0, 1'b1, 1'b0, 32'h0,        1};
      vt[3]  = '{1'b1, 30'h30,       32'h00000000, 4'h5, 4'd0, 1'b1, 1'b0, 32'h0,        1};
      vt[4]  = '{1'b0, 30'h30,       32'h0,        4'hF, 4'd0, 1'b1, 1'b0, 32'hFF00FF00, 1};
      vt[5]  = '{1'b0, 30'h10,       32'h0,        4'hF, 4'd3, 1'b1, 1'b0, 32'h11223344, 4};
      vt[6]  = '{1'b0, 30'h100,      32'h0,        4'hF, 4'd0, 1'b0, 1'b1, 32'h0,        1};
      vt[7]  = '{1'b1, 30'h3FFFFFFF, 32'h0,        4'hF, 4'd1, 1'b0, 1'b1, 32'h0,        2};
      vt[8]  = '{1'b1, 30'hFF,       32'hA5A5A5A5, 4'hF, 4'd2, 1'b1, 1'b0, 32'h0,        3};
      vt[9]  = '{1'b0, 30'hFF,       32'h0,        4'hF, 4'd2, 1'b1, 1'b0, 32'hA5A5A5A5, 3};
      vt[10] = '{1'b1, 30'h31,       32'h12345678, 4'hF, 4'd0, 1'b1, 1'b0, 32'h0,        1};
      vt[11] = '{1'b1, 30'h31,       32'hAABBCCDD, 4'hC, 4'd0, 1'b1, 1'b0, 32'h0,        1};
      vt[12] = '{1'b0, 30'h31,       32'h0,        4'hF, 4'd0, 1'b1, 1'b0, 32'hAABB5678, 1};

      bvals[0] = 32'h11223344; bvals[1] = 32'h22334455; bvals[2] = 32'h33445566;
      bvals[3] = 32'h44556677; bvals[4] = 32'h55667788;

      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; dat_w = '0;
      sel = 4'hF; cti = 3'b000; cfg_wait = 4'd0;
      exp_wr = 16'd0; exp_rd = 16'd0;
      #12;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_dat", dat_r, 32'd0);
      chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector table of classic accesses
      t0 = cyc_no;
      for (int i = 0; i < 13; i++) begin
         bdat[0] = vt[i].data;
         bsel[0] = vt[i].sel;
         xfer(vt[i].we, vt[i].addr, 1, vt[i].w, 1'b1);
         chk("vec_ack", 32'(obs_ack[0]), 32'(vt[i].exp_ack));
         chk("vec_err", 32'(obs_err[0]), 32'(vt[i].exp_err));
         chk("vec_latency", obs_lat, vt[i].exp_lat);
         if (!vt[i].we && vt[i].exp_ack) chk("vec_rdata", rdat[0], vt[i].exp_rd);
         if (i == 1) begin
            chk("pair_wr_cnt", 32'(wr_cnt), 32'd1);
            chk("pair_rd_cnt", 32'(rd_cnt), 32'd1);
            chk("pair_cycles", cyc_no - t0, 32'd4);
         end
      end

      // 5-beat write burst then read-back burst
      for (int i = 0; i < 5; i++) begin bdat[i] = bvals[i]; bsel[i] = 4'hF; end
      xfer(1'b1, 30'h20, 5, 4'd0, 1'b0);
      xfer(1'b0, 30'h20, 5, 4'd0, 1'b0);
      chk("burst_beats", obs_beats, 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk("burst_ack", 32'(obs_ack[i]), 32'd1);
         chk("burst_data", rdat[i], bvals[i]);
      end
      xfer(1'b0, 30'h24, 1, 4'd0, 1'b1);
      chk("post_burst_latency", obs_lat, 32'd1);
      chk("post_burst_data", rdat[0], 32'h55667788);

      // cfg_wait changed while a cycle is in its wait phase
      mid_wait = 0;
      xfer(1'b0, 30'h10, 1, 4'd3, 1'b1);
      chk("midwait_latency", obs_lat, 32'd4);
      mid_wait = -1;

      // Burst running off the top of memory
      for (int i = 0; i < 4; i++) begin bdat[i] = 32'hC0DE0000 + 32'(i); bsel[i] = 4'hF; end
      xfer(1'b1, 30'hFE, 4, 4'd0, 1'b0);
      chk("edge_beats", obs_beats, 32'd3);
      chk("edge_ack0", 32'(obs_ack[0]), 32'd1);
      chk("edge_ack1", 32'(obs_ack[1]), 32'd1);
      chk("edge_err2", 32'(obs_err[2]), 32'd1);

      // Abort a write during its wait phase
      cfg_wait = 4'd5;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h10; dat_w = 32'hDEADBEEF; sel = 4'hF;
      saw = 1'b0;
      repeat (2) begin @(posedge clk); #1; saw = saw | ack | err; end
      cyc = 1'b0; stb = 1'b0;
      repeat (8) begin @(posedge clk); #1; saw = saw | ack | err; end
      chk("abort_no_term", 32'(saw), 32'd0);
      chk("abort_wr_cnt", 32'(wr_cnt), 32'(exp_wr));
      xfer(1'b0, 30'h10, 1, 4'd0, 1'b1);
      chk("abort_mem_kept", rdat[0], 32'h11223344);

      // Preload every word, then randomized traffic
      for (int i = 0; i < 256; i++) begin bdat[i] = $urandom; bsel[i] = 4'hF; end
      xfer(1'b1, 30'h0, 256, 4'd0, 1'b0);
      for (int t = 0; t < 60; t++) begin
         rwe = 1'($urandom_range(0, 1));
         n   = (t % 3 == 0) ? 1 : int'($urandom_range(1, 8));
         cls = (n == 1) && ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0, 1:    ra = 30'($urandom_range(0, 255));
            2:       ra = 30'($urandom_range(248, 258));
            default: ra = 30'($urandom);
         endcase
         rw = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
         for (int i = 0; i < n; i++) begin bdat[i] = $urandom; bsel[i] = 4'($urandom); end
         xfer(rwe, ra, n, rw, cls);
      end

      // Asynchronous reset in the middle of a read burst
      cfg_wait = 4'd0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h20; cti = 3'b010;
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_reset_ack", 32'(ack), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_ack", 32'(ack), 32'd0);
      chk("async_rst_err", 32'(err), 32'd0);
      chk("async_rst_dat", dat_r, 32'd0);
      chk("async_rst_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("async_rst_rd_cnt", 32'(rd_cnt), 32'd0);
      cyc = 1'b0; stb = 1'b0; cti = 3'b000;
      @(negedge clk); rst_n = 1'b1;
      exp_wr = 16'd0; exp_rd = 16'd0;
      @(posedge clk); #1;
      xfer(1'b0, 30'h20, 1, 4'd0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/wb_burst_responder.md
Name: wb_burst_responder

Overview:
Synthesizable Wishbone B3 slave (responder) with internal word-addressed memory. It answers the same classic and incrementing-burst wishbone traffic that the sdrc_top host port receives. It serves as a known-good far end for bench masters and FPGA bring-up traffic generators, and as an on-chip scratch memory. Programmable wait states, an error response for out-of-range addresses, and transfer counters are included.

Parameters:
AW, 8, word-address width of internal memory; DEPTH = 2**AW 32-bit words
dw, 32, data width (fixed at 32; sel width dw/8)

Ports:
wb_clk_i  in  1  clock; all logic on rising edge
wb_resetn  in  1  reset, asynchronous, active-low
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  transfer strobe
wb_we_i  in  1  1 = write, 0 = read
wb_addr_i  in  30  word address (byte address [31:2])
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables; bit n covers dat[8n+7:8n]
wb_cti_i  in  3  3'b000 classic, 3'b010 incrementing burst, 3'b111 end-of-burst; others treated as classic
wb_dat_o  out  32  read data; valid only while wb_ack_o=1, else 0
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
cfg_wait  in  4  wait states inserted before first ack of each cycle/burst (0-15)
wr_cnt_o  out  16  count of acked write beats, wraps at 16'hFFFF
rd_cnt_o  out  16  count of acked read beats, wraps

Behaviour:
- Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wr_cnt_o=0, rd_cnt_o=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- req = wb_cyc_i & wb_stb_i. in_range = (wb_addr_i[29:AW] == 0) for the address being acked.
- FSM states: IDLE, WAIT, ACK, BURST. wb_ack_o/wb_err_o are registered.
- IDLE: on req at edge k:
  - cfg_wait=0 -> ACK; otherwise load counter=cfg_wait, go to WAIT.
  - Latch the beat address into addr counter.
- WAIT: decrement each edge. When the counter reaches 1, go to ACK. First termination is high during cycle k+1+W (W=cfg_wait).
- ACK (one cycle of ack or err):
  - Write: if in_range and wb_we_i, write bytes selected by wb_sel_i at this edge; wr_cnt_o+1.
  - Read: wb_dat_o=mem[addr], registered in the same edge the ack is set; rd_cnt_o+1 when the ack cycle completes.
  - Out of range: err instead of ack, no write, no count, go to IDLE.
- Next state after ACK:
  - cti=010 and req: go to BURST; addr counter +1.
  - Otherwise (classic, 111, or other): go to IDLE, which deasserts ack for at least one cycle. Back-to-back classic costs 2+W cycles per beat.
- BURST: ack stays high every cycle while req and cti=010, one beat per edge, no further wait states.
  - Writes use the current wb_dat_i/wb_sel_i; read data is prefetched from addr counter.
  - cti=111 beat: acked, then go to IDLE.
  - Addr counter leaves range mid-burst: that beat gets err (ack=0), burst ends, go to IDLE.
- Abort: wb_cyc_i=0 in any non-IDLE state -> next edge IDLE; ack/err=0; the pending beat is not written or counted.
- wb_stb_i=0 with wb_cyc_i=1 in BURST: hold state, ack=0 (master stall); resume on stb.
- ack and err are never high together. Neither is high in a cycle where req was low at the prior edge, except the registered tail of an aborted beat, which is suppressed.
- Async reset mid-burst: all outputs to reset values immediately; memory write is not performed.
- cfg_wait is sampled only in IDLE; changes mid-cycle have no effect until the next cycle.

Test Plan:
- Classic write then read, cfg_wait=0: write 32'h11223344 to addr 30'h10, sel 4'hF, then read -> ack 1 cycle each, 2 cycles per beat, rd data 32'h11223344, wr_cnt_o=1, rd_cnt_o=1.
- 5-beat incrementing burst (cti 010,010,010,010,111) at addr 30'h20, data 11223344, 22334455, 33445566, 44556677, 55667788; read back as a burst -> 5 consecutive ack cycles, all match, FSM IDLE after last beat.
- Byte enables: preload 32'hFFFFFFFF, write 32'h00000000 with sel 4'b0101 -> readback 32'hFF00FF00.
- cfg_wait=3 classic read -> ack rises exactly 4 cycles after request edge; change cfg_wait mid-cycle -> no effect.
- Out of range: AW=8, read at 30'h100 -> err 1 cycle, ack 0, counters unchanged. Burst starting at 30'hFE for 4 beats -> ack, ack, then err on beat 3, then IDLE.
- Abort and reset: drop wb_cyc_i during WAIT of a write -> no ack, memory unchanged. Assert wb_resetn=0 mid-burst -> ack/err/dat/counters go to 0 asynchronously.
